vga_fb_reader: RTL

//  Display-side reader of the dual-clock frame buffer. Generates VGA raster timing and

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_timing_gen.sv | 75 +++++++
 rtl/vga_fb_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster constants and timing derivation helpers
//
// Purpose: default VGA timing, sync polarity and frame size shared by the
// display reader and the capture side, plus helpers that derive totals and
// sync windows from active/porch/sync widths. Also holds the RGB444 colour-bar
// table used when the reader is built with TEST_PATTERN_EN.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam bit SYNC_POL_DEF = 1'b0;

  // Frame size shared with the writer side of the frame buffer.
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync window is [sync_start, sync_end) in counter units.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  // Eight vertical bars, left to right: white, yellow, cyan, green,
  // magenta, red, blue, black.
  function automatic logic [11:0] bar_rgb444(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA h/v raster counters with active/sync decode and frame_start
//
// Purpose: raster position counters advanced by pix_en, decoded into active
// and sync flags (1 = inside region, polarity applied downstream).
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   pix_en         advance raster one pixel this cycle
//   h_cnt          registered horizontal position
//   active         h_cnt/v_cnt inside the visible area (combinational)
//   hsync, vsync   inside the sync windows (combinational)
//   frame_end      current position is the last pixel of the frame (combinational)
//   frame_start    1-clk pulse after the raster wraps to (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_end,
  output logic          frame_start
);

  localparam int HS0 = sync_start(H_ACTIVE, H_FP);
  localparam int HS1 = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS0 = sync_start(V_ACTIVE, V_FP);
  localparam int VS1 = sync_end(V_ACTIVE, V_FP, V_SYNC);

  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_end = h_last & v_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & frame_end;
      if (pix_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hsync  = (h_cnt >= HW'(HS0)) && (h_cnt < HW'(HS1));
  assign vsync  = (v_cnt >= VW'(VS0)) && (v_cnt < VW'(VS1));

endmodule

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - display-side frame buffer reader with VGA timing and RGB pipeline
//
// Purpose: walks the frame buffer read port in raster order and pipelines the
// returned pixels to the DAC with hsync/vsync delayed to stay aligned (2 clks).
// Build option: TEST_PATTERN_EN replaces read data with 8 vertical colour bars;
// the read port is driven identically either way.
// Ports:
//   r_clk, r_rstn   display clock, synchronous active-low reset
//   i_pix_en        pixel tick; raster advances one pixel per high cycle
//   o_r_en/o_r_addr frame buffer read request (data returns 1 clk later)
//   i_r_dout        frame buffer read data
//   o_rgb           pixel to DAC, 0 during blanking
//   o_hsync/o_vsync syncs at level SYNC_POL when asserted
//   o_frame_start   1-clk pulse when the raster wraps to (0,0)
module vga_fb_reader
  import vga_timing_pkg::*;
#(
  parameter int  DATA_WIDTH = 12,
  parameter int  H_ACTIVE   = H_ACTIVE_DEF,
  parameter int  H_FP       = H_FP_DEF,
  parameter int  H_SYNC     = H_SYNC_DEF,
  parameter int  H_BP       = H_BP_DEF,
  parameter int  V_ACTIVE   = V_ACTIVE_DEF,
  parameter int  V_FP       = V_FP_DEF,
  parameter int  V_SYNC     = V_SYNC_DEF,
  parameter int  V_BP       = V_BP_DEF,
  parameter bit  SYNC_POL   = SYNC_POL_DEF,
  parameter int  DEPTH      = H_ACTIVE * V_ACTIVE,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int HW         = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP))
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic                  i_pix_en,
  output logic                  o_r_en,
  output logic [ADDR_W-1:0]     o_r_addr,
  input  logic [DATA_WIDTH-1:0] i_r_dout,
  output logic [DATA_WIDTH-1:0] o_rgb,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_frame_start
);

  logic                  active;
  logic                  hsync;
  logic                  vsync;
  logic                  frame_end;
  logic [ADDR_W-1:0]     addr;
  logic                  p1_en;
  logic                  p1_active;
  logic                  p1_hs;
  logic                  p1_vs;
  logic [DATA_WIDTH-1:0] pix_data;
`ifdef TEST_PATTERN_EN
  logic [HW-1:0]         h_cnt;
  logic [HW-1:0]         h_cnt_d;
`endif

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (r_clk),
    .rstn        (r_rstn),
    .pix_en      (i_pix_en),
`ifdef TEST_PATTERN_EN
    .h_cnt       (h_cnt),
`else
    .h_cnt       (),
`endif
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_end   (frame_end),
    .frame_start (o_frame_start)
  );

  // Gated by reset so no read is issued while the raster is being cleared.
  assign o_r_en   = r_rstn & i_pix_en & active;
  assign o_r_addr = addr;

  // The last pixel of a frame is always in blanking, so the end-of-frame
  // clear never competes with an active increment. The DEPTH-1 wrap only
  // matters if DEPTH is configured smaller than the visible area.
  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      addr <= '0;
    end else if (i_pix_en) begin
      if (frame_end) begin
        addr <= '0;
      end else if (active) begin
        addr <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
      end
    end
  end

`ifdef TEST_PATTERN_EN
  always_comb begin
    int bar;
    bar      = (int'(h_cnt_d) * 8) / H_ACTIVE;
    pix_data = DATA_WIDTH'(bar_rgb444(3'(bar)));
  end
`else
  assign pix_data = i_r_dout;
`endif

  // Stage 1 captures the raster flags while the BRAM produces data; stage 2
  // commits pixel and syncs together only for cycles that were pixel ticks.
  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      p1_en     <= 1'b0;
      p1_active <= 1'b0;
      p1_hs     <= 1'b0;
      p1_vs     <= 1'b0;
`ifdef TEST_PATTERN_EN
      h_cnt_d   <= '0;
`endif
      o_rgb     <= '0;
      o_hsync   <= ~SYNC_POL;
      o_vsync   <= ~SYNC_POL;
    end else begin
      p1_en     <= i_pix_en;
      p1_active <= active;
      p1_hs     <= hsync;
      p1_vs     <= vsync;
`ifdef TEST_PATTERN_EN
      h_cnt_d   <= h_cnt;
`endif
      if (p1_en) begin
        o_rgb   <= p1_active ? pix_data : '0;
        o_hsync <= p1_hs ? SYNC_POL : ~SYNC_POL;
        o_vsync <= p1_vs ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule
